frame_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares the 16-bit frame_detector input bus among 8 payload requesters.
- For each granted requester it sequences one complete frame onto the bus: header, one-hot channel word, 1–8 payload words, CRC-16, trailer and idle gap.
- Sits upstream of frame_detector in the clk_in domain and drives its data_in port.

---
 rtl/frame_tx_if.sv | 27 ++
 rtl/frame_tx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_frame_tx_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_tx_if.sv
// Bundle of request, payload and frame-bus signals between frame_tx_scheduler
// and its eight payload requesters / the downstream frame_detector.
interface frame_tx_if;
  logic [7:0]  req;
  logic [23:0] req_len;
  logic        crc_corrupt;
  logic [7:0]  gnt;
  logic        pl_rd;
  logic [2:0]  pl_sel;
  logic [15:0] pl_data;
  logic [15:0] data_out;
  logic        busy;
  logic [7:0]  done;
  logic [15:0] frame_cnt;

  // Scheduler side.
  modport master (
    input  req, req_len, crc_corrupt, pl_data,
    output gnt, pl_rd, pl_sel, data_out, busy, done, frame_cnt
  );

  // Requester / observer side.
  modport slave (
    output req, req_len, crc_corrupt, pl_data,
    input  gnt, pl_rd, pl_sel, data_out, busy, done, frame_cnt
  );
endinterface

// File: rtl/frame_tx_scheduler.sv
// Round-robin frame scheduler: grants one of eight requesters and serialises
// header, channel word, 1..8 payload words, CRC-16/XMODEM, trailer and an
// idle gap onto the registered 16-bit frame bus.
module frame_tx_scheduler #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [31:0] HEADER     = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER    = 32'h0E0E0E0E
) (
  input  logic       clk_in,
  input  logic       rst,
  frame_tx_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_CHAN, S_PAY,
    S_CRC, S_TRL_HI, S_TRL_LO, S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  rr_ptr;
  logic [2:0]  sel;
  logic [2:0]  len_m1;
  logic [2:0]  word_cnt;
  logic        corrupt;
  logic [15:0] crc;
  logic [3:0]  gap_cnt;
  logic [15:0] data_nxt;
  logic        rd;
  logic        req_any;
  logic [2:0]  pick;
  logic [7:0]  gnt_r, done_r;
  logic [15:0] data_r, frame_cnt_r;

  // One 16-bit word folded into CRC-16/XMODEM, MSB first; unrolls to XOR trees.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [7:0] one_hot(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Round-robin pick: first requesting channel at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    logic       found;
    logic [2:0] idx;
    found   = 1'b0;
    idx     = '0;
    pick    = rr_ptr;
    req_any = |bus.req;
    for (int i = 0; i < 8; i++) begin
      idx = rr_ptr + i[2:0];
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, next bus word and the payload read strobe.
  always_comb begin
    state_nxt = state;
    data_nxt  = 16'h0000;
    rd        = 1'b0;
    unique case (state)
      S_IDLE: if (req_any) begin
        state_nxt = S_HDR_HI;
        data_nxt  = HEADER[31:16];
      end
      S_HDR_HI: begin
        state_nxt = S_HDR_LO;
        data_nxt  = HEADER[15:0];
      end
      S_HDR_LO: begin
        state_nxt = S_CHAN;
        data_nxt  = {8'h00, one_hot(sel)};
      end
      S_CHAN: begin
        rd        = 1'b1;
        state_nxt = S_PAY;
        data_nxt  = bus.pl_data;
      end
      // word_cnt is the index of the payload word currently on the bus.
      S_PAY: if (word_cnt == len_m1) begin
        state_nxt = S_CRC;
        data_nxt  = corrupt ? ~crc : crc;
      end else begin
        rd       = 1'b1;
        data_nxt = bus.pl_data;
      end
      S_CRC: begin
        state_nxt = S_TRL_HI;
        data_nxt  = TRAILER[31:16];
      end
      S_TRL_HI: begin
        state_nxt = S_TRL_LO;
        data_nxt  = TRAILER[15:0];
      end
      S_TRL_LO: state_nxt = S_GAP;
      S_GAP: if (gap_cnt == 4'(GAP_CYCLES - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant latching, payload counting, CRC accumulation and frame statistics.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      rr_ptr      <= '0;
      sel         <= '0;
      len_m1      <= '0;
      word_cnt    <= '0;
      corrupt     <= 1'b0;
      crc         <= '0;
      gap_cnt     <= '0;
      gnt_r       <= '0;
      done_r      <= '0;
      data_r      <= '0;
      frame_cnt_r <= '0;
    end else begin
      data_r <= data_nxt;
      gnt_r  <= '0;
      done_r <= '0;
      case (state)
        S_IDLE: if (req_any) begin
          gnt_r   <= one_hot(pick);
          sel     <= pick;
          len_m1  <= bus.req_len[pick*3 +: 3];
          corrupt <= bus.crc_corrupt;
          rr_ptr  <= pick + 3'd1;
          crc     <= '0;
        end
        S_CHAN: begin
          word_cnt <= '0;
          crc      <= crc16_step(crc, bus.pl_data);
        end
        S_PAY: if (rd) begin
          word_cnt <= word_cnt + 3'd1;
          crc      <= crc16_step(crc, bus.pl_data);
        end
        S_TRL_LO: begin
          done_r      <= one_hot(sel);
          frame_cnt_r <= frame_cnt_r + 16'd1;
          gap_cnt     <= '0;
        end
        S_GAP: gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.data_out  = data_r;
  assign bus.frame_cnt = frame_cnt_r;
  assign bus.pl_sel    = sel;
  assign bus.pl_rd     = rd;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Scoreboard bench for frame_tx_scheduler: stimulus pushes the expected bus
// cycles of each frame; a per-instance monitor pops one entry per busy cycle.
// Instance 0 uses GAP_CYCLES=1, instance 1 uses GAP_CYCLES=4.
module tb_frame_tx_scheduler;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  gnt;
    logic [7:0]  done;
    logic        rd;
    int          pre_idle;
    logic [15:0] cnt;
  } exp_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_v       [2];
  logic [7:0]  req_v       [2];
  logic [23:0] len_v       [2];
  logic        corrupt_v   [2];
  logic [7:0]  gnt_v       [2];
  logic [7:0]  done_v      [2];
  logic        busy_v      [2];
  logic [15:0] data_out_v  [2];
  logic [15:0] frame_cnt_v [2];
  logic [15:0] pay [2][8][8];
  exp_t        exp_q [2][$];
  int          frames_pushed [2];
  int          total = 0;
  int          bad   = 0;

  frame_tx_if bus [2] ();

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    int rd_idx   = 0;
    int idle_run = 0;

    frame_tx_scheduler #(.GAP_CYCLES(gi == 0 ? 1 : 4)) dut (
      .clk_in (clk_in),
      .rst    (rst_v[gi]),
      .bus    (bus[gi])
    );

    assign bus[gi].req         = req_v[gi];
    assign bus[gi].req_len     = len_v[gi];
    assign bus[gi].crc_corrupt = corrupt_v[gi];
    assign bus[gi].pl_data     = pay[gi][bus[gi].pl_sel][rd_idx % 8];
    assign gnt_v[gi]           = bus[gi].gnt;
    assign done_v[gi]          = bus[gi].done;
    assign busy_v[gi]          = bus[gi].busy;
    assign data_out_v[gi]      = bus[gi].data_out;
    assign frame_cnt_v[gi]     = bus[gi].frame_cnt;

    // Requester model: word index within the granted channel's payload.
    always @(posedge clk_in) begin
      if (bus[gi].gnt != 8'h00) rd_idx <= 0;
      else if (bus[gi].pl_rd)   rd_idx <= rd_idx + 1;
    end

    // Monitor: one scoreboard entry per busy cycle, quiet bus otherwise.
    always @(negedge clk_in) begin
      exp_t e;
      if (rst_v[gi]) begin
        idle_run = 0;
      end else if (busy_v[gi]) begin
        if (exp_q[gi].size() == 0) begin
          fail_now("unexpected_busy");
        end else begin
          e = exp_q[gi].pop_front();
          if (e.pre_idle >= 0) check("idle_before_frame", idle_run, e.pre_idle);
          check("data_out", data_out_v[gi], e.data);
          check("gnt", gnt_v[gi], e.gnt);
          check("done", done_v[gi], e.done);
          check("pl_rd", bus[gi].pl_rd, e.rd);
          if (e.done != 8'h00) check("frame_cnt", frame_cnt_v[gi], e.cnt);
        end
        idle_run = 0;
      end else begin
        check("idle_outputs", {data_out_v[gi], gnt_v[gi], done_v[gi]}, 32'h0);
        idle_run++;
      end
    end
  end

  // Reference CRC-16/XMODEM: XOR the word in, then 16 shift/reduce steps.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    repeat (16) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  task automatic push(int inst, logic [15:0] d, logic [7:0] g, logic [7:0] dn,
                      logic rd, int pre, logic [15:0] cnt);
    exp_t e;
    e.data = d; e.gnt = g; e.done = dn; e.rd = rd; e.pre_idle = pre; e.cnt = cnt;
    exp_q[inst].push_back(e);
  endtask

  // Expected bus cycles of one frame; crc_hand >= 0 gives a hand-computed CRC word.
  task automatic push_frame(int inst, int ch, int pre, logic corrupt, int crc_hand);
    logic [7:0]  oh;
    logic [2:0]  fld;
    logic [15:0] c;
    int          n;
    int          gap;
    oh  = 8'h01 << ch;
    fld = len_v[inst][ch*3 +: 3];
    n   = int'(fld) + 1;
    gap = (inst == 0) ? 1 : 4;
    c   = 16'h0000;
    push(inst, 16'hE0E0, oh, 8'h00, 1'b0, pre, 16'h0);
    push(inst, 16'hE0E0, 8'h00, 8'h00, 1'b0, -1, 16'h0);
    push(inst, {8'h00, oh}, 8'h00, 8'h00, 1'b1, -1, 16'h0);
    for (int w = 0; w < n; w++) begin
      c = crc_model(c, pay[inst][ch][w]);
      push(inst, pay[inst][ch][w], 8'h00, 8'h00, (w < n - 1), -1, 16'h0);
    end
    if (crc_hand >= 0) push(inst, 16'(crc_hand), 8'h00, 8'h00, 1'b0, -1, 16'h0);
    else               push(inst, corrupt ? ~c : c, 8'h00, 8'h00, 1'b0, -1, 16'h0);
    push(inst, 16'h0E0E, 8'h00, 8'h00, 1'b0, -1, 16'h0);
    push(inst, 16'h0E0E, 8'h00, 8'h00, 1'b0, -1, 16'h0);
    frames_pushed[inst]++;
    for (int g = 0; g < gap; g++)
      push(inst, 16'h0000, 8'h00, (g == 0) ? oh : 8'h00, 1'b0, -1, 16'(frames_pushed[inst]));
  endtask

  task automatic wait_gnt(int inst, int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 400 * n) begin
      @(negedge clk_in);
      cyc++;
      if (gnt_v[inst] != 8'h00) seen++;
    end
    if (seen < n) fail_now("gnt_timeout");
  endtask

  task automatic wait_drain(int inst);
    int cyc = 0;
    do begin
      @(negedge clk_in);
      #1;
      cyc++;
    end while ((exp_q[inst].size() != 0 || busy_v[inst]) && cyc < 2000);
    if (exp_q[inst].size() != 0 || busy_v[inst]) fail_now("drain_timeout");
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; req_v[i] = 8'h00; len_v[i] = 24'h0; corrupt_v[i] = 1'b0;
      frames_pushed[i] = 0;
      for (int k = 0; k < 8; k++)
        for (int w = 0; w < 8; w++) pay[i][k][w] = 16'h0000;
    end
    repeat (3) @(negedge clk_in);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    @(negedge clk_in);
    check("reset_frame_cnt", frame_cnt_v[0], 16'h0);
    check("reset_busy", busy_v[0], 1'b0);
    check("reset_pl_sel_rd", {bus[0].pl_sel, bus[0].pl_rd}, 4'h0);

    // Reset during PAY of a 5-word ch3 frame aborts it.
    len_v[0] = 24'd4 << 6;
    for (int w = 0; w < 8; w++) pay[0][2][w] = 16'h3000 + 16'(w);
    push_frame(0, 2, -1, 1'b0, -1);
    req_v[0] = 8'h04;
    wait_gnt(0, 1);
    req_v[0] = 8'h00;
    repeat (3) @(posedge clk_in);
    #2;
    rst_v[0] = 1'b1;
    #1;
    check("abort_data_out", data_out_v[0], 16'h0);
    check("abort_busy", busy_v[0], 1'b0);
    exp_q[0].delete();
    frames_pushed[0] = 0;
    @(negedge clk_in);
    rst_v[0] = 1'b0;
    @(negedge clk_in);
    check("abort_frame_cnt", frame_cnt_v[0], 16'h0);
    check("abort_done", done_v[0], 8'h00);

    // Single-word ch1 frame with hand-computed CRC, then the corrupted CRC.
    len_v[0] = 24'h0;
    pay[0][0][0] = 16'hA55A;
    push_frame(0, 0, -1, 1'b0, 16'h1934);
    req_v[0] = 8'h01;
    wait_gnt(0, 1);
    req_v[0] = 8'h00;
    wait_drain(0);
    check("frame_cnt_after_first", frame_cnt_v[0], 16'd1);

    push_frame(0, 0, -1, 1'b1, 16'hE6CB);
    corrupt_v[0] = 1'b1;
    req_v[0] = 8'h01;
    wait_gnt(0, 1);
    req_v[0] = 8'h00;
    corrupt_v[0] = 1'b0;
    wait_drain(0);

    // ch8 alone moves the pointer back to ch1.
    len_v[0] = 24'd2 << 21;
    for (int w = 0; w < 8; w++) pay[0][7][w] = 16'h8000 + 16'(w * 3);
    push_frame(0, 7, -1, 1'b0, -1);
    req_v[0] = 8'h80;
    wait_gnt(0, 1);
    req_v[0] = 8'h00;
    wait_drain(0);

    // ch8 and ch1 together after a ch8 grant: ch1 first, then ch8.
    len_v[0] = (24'd2 << 21) | 24'd1;
    pay[0][0][0] = 16'h1234;
    pay[0][0][1] = 16'hFEDC;
    push_frame(0, 0, -1, 1'b0, -1);
    push_frame(0, 7, 1, 1'b0, -1);
    req_v[0] = 8'h81;
    wait_gnt(0, 2);
    req_v[0] = 8'h00;
    wait_drain(0);

    // All channels requesting with 8-word payloads: ch1..ch8, then ch1.
    len_v[0] = 24'hFFFFFF;
    for (int k = 0; k < 8; k++)
      for (int w = 0; w < 8; w++) pay[0][k][w] = 16'(k * 16'h1111) ^ 16'(w * 16'h0203) ^ 16'h5A00;
    for (int k = 0; k < 8; k++) push_frame(0, k, (k == 0) ? -1 : 1, 1'b0, -1);
    push_frame(0, 0, 1, 1'b0, -1);
    req_v[0] = 8'hFF;
    wait_gnt(0, 9);
    req_v[0] = 8'h00;
    wait_drain(0);
    check("frame_cnt_total", frame_cnt_v[0], 16'(frames_pushed[0]));

    // GAP_CYCLES=4 instance, back-to-back ch1 and ch2 frames.
    pay[1][0][0] = 16'h1111;
    pay[1][1][0] = 16'h2222;
    push_frame(1, 0, -1, 1'b0, -1);
    push_frame(1, 1, 1, 1'b0, -1);
    req_v[1] = 8'h03;
    wait_gnt(1, 2);
    req_v[1] = 8'h00;
    wait_drain(1);
    check("gap4_frame_cnt", frame_cnt_v[1], 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
